sha256_msg_sequencer: RTL and testbench

- Front-end controller for the SHA256 compression core. Accepts the byte stream (load_enable / input_complete / input_data), buffers one 64-byte block and applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length).
- Sequences the resulting 512-bit blocks into the core as 16 big-endian 32-bit words, then waits for the core's per-block completion before releasing the next block.
- Sits between the byte input and the message-schedule/compression datapath. It replaces the core's direct byte loading.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_pad_word.sv | 46 ++++
 rtl/sha256_msg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message front end.
//   state_e         - sequencer FSM states
//   BLOCK_BYTES     - bytes per 512-bit block
//   LEN_POS         - first byte position of the 64-bit length field
//   PAD_MARKER      - the single '1' bit appended after the message
//   WORDS_PER_BLOCK - 32-bit words delivered to the core per block
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int         BLOCK_BYTES     = 64;
  localparam int         LEN_POS         = 56;
  localparam logic [7:0] PAD_MARKER      = 8'h80;
  localparam int         WORDS_PER_BLOCK = 16;

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: builds one big-endian 32-bit block word from buffered
// message bytes plus the padding rules (0x80 marker, zero fill, 64-bit
// length in the last block). Purely combinational.
//   slice_i         - buffer bytes 4*word_index_i .. +3, first byte in [31:24]
//   word_index_i    - word position 0..15 within the block
//   fill_idx_i      - number of valid message bytes in this block
//   complete_seen_i - end of message has been received
//   marker_sent_i   - the 0x80 marker already went out in an earlier block
//   block_last_i    - this block carries the length field
//   bit_len_i       - message length in bits
//   word_o          - assembled word
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] slice_i,
  input  logic [3:0]  word_index_i,
  input  logic [6:0]  fill_idx_i,
  input  logic        complete_seen_i,
  input  logic        marker_sent_i,
  input  logic        block_last_i,
  input  logic [63:0] bit_len_i,
  output logic [31:0] word_o
);

  // Length bytes only ever land in words 14 and 15, so the word's low
  // index bit picks the upper or lower half of the length.
  logic [31:0] len_word;
  assign len_word = word_index_i[0] ? bit_len_i[31:0] : bit_len_i[63:32];

  always_comb begin
    logic [6:0] pos;
    pos    = '0;
    word_o = '0;
    for (int k = 0; k < 4; k++) begin
      pos = {1'b0, word_index_i, 2'(k)};
      if (pos < fill_idx_i) begin
        word_o[31-8*k -: 8] = slice_i[31-8*k -: 8];
      end else if ((pos == fill_idx_i) && complete_seen_i && !marker_sent_i) begin
        word_o[31-8*k -: 8] = PAD_MARKER;
      end else if (block_last_i && (pos >= 7'(LEN_POS))) begin
        word_o[31-8*k -: 8] = len_word[31-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: buffers the incoming byte stream one 64-byte block
// at a time, applies SHA-256 padding and hands each block to the
// compression core as 16 big-endian words, waiting for the core between
// blocks.
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   load_enable_i          - input_data_i holds a valid byte
//   input_complete_i       - end-of-message pulse
//   input_data_i           - message byte
//   input_ready_o          - byte / complete accepted this cycle
//   word_valid_o           - word_data_o valid, core must take it
//   word_data_o            - block word
//   word_index_o           - word position 0..15
//   block_first_o          - block in flight is the message's first
//   block_last_o           - block in flight is the final padded block
//   core_block_done_i      - core finished the current block
//   msg_done_o             - pulse after the final block completes
//   error_o                - sticky length overflow / watchdog error
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int LEN_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_enable_i,
  input  logic        input_complete_i,
  input  logic [7:0]  input_data_i,
  output logic        input_ready_o,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic [3:0]  word_index_o,
  output logic        block_first_o,
  output logic        block_last_o,
  input  logic        core_block_done_i,
  output logic        msg_done_o,
  output logic        error_o
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_e              state_q;
  logic [7:0]          buffer_q [BLOCK_BYTES];
  logic [6:0]          fill_idx_q;
  logic [LEN_W-1:0]    byte_count_q;
  logic [3:0]          word_idx_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                complete_seen_q;
  logic                marker_sent_q;
  logic                first_q;
  logic                last_q;
  logic                input_ready_q;
  logic                word_valid_q;
  logic                msg_done_q;
  logic                error_q;

  logic                accepting;
  logic                count_full;
  logic                byte_write;
  logic                last_now;
  logic                marker_here;
  logic                block_last;
  logic                in_block;
  logic [63:0]         bit_len;
  logic [31:0]         slice;
  logic [31:0]         pad_word;

  assign accepting  = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign count_full = &byte_count_q;
  // A byte that would wrap the length counter is dropped.
  assign byte_write = accepting && load_enable_i && !input_complete_i && !count_full;
  assign bit_len    = 64'({byte_count_q, 3'b000});

  assign last_now    = complete_seen_q && (marker_sent_q || (fill_idx_q <= 7'(LEN_POS - 1)));
  assign marker_here = complete_seen_q && !marker_sent_q && (fill_idx_q < 7'(BLOCK_BYTES));
  // marker_sent flips at the end of EMIT, which would change last_now while
  // waiting on the core; WAIT therefore uses the value captured from EMIT.
  assign block_last  = (state_q == ST_WAIT) ? last_q : last_now;
  assign in_block    = (state_q == ST_EMIT) || (state_q == ST_WAIT);

  assign slice = {buffer_q[{word_idx_q, 2'd0}], buffer_q[{word_idx_q, 2'd1}],
                  buffer_q[{word_idx_q, 2'd2}], buffer_q[{word_idx_q, 2'd3}]};

  sha256_pad_word u_pad_word (
    .slice_i         (slice),
    .word_index_i    (word_idx_q),
    .fill_idx_i      (fill_idx_q),
    .complete_seen_i (complete_seen_q),
    .marker_sent_i   (marker_sent_q),
    .block_last_i    (last_now),
    .bit_len_i       (bit_len),
    .word_o          (pad_word)
  );

  // Buffer storage carries no reset: stale bytes are always masked by fill_idx.
  always_ff @(posedge clk_i) begin
    if (byte_write) begin
      buffer_q[fill_idx_q[5:0]] <= input_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      fill_idx_q      <= '0;
      byte_count_q    <= '0;
      word_idx_q      <= '0;
      wait_cnt_q      <= '0;
      complete_seen_q <= 1'b0;
      marker_sent_q   <= 1'b0;
      first_q         <= 1'b1;
      last_q          <= 1'b0;
      input_ready_q   <= 1'b1;
      word_valid_q    <= 1'b0;
      msg_done_q      <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      msg_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FILL: begin
          if (input_complete_i) begin
            complete_seen_q <= 1'b1;
            state_q         <= ST_EMIT;
            input_ready_q   <= 1'b0;
            word_valid_q    <= 1'b1;
            word_idx_q      <= '0;
          end else if (byte_write) begin
            fill_idx_q   <= fill_idx_q + 7'd1;
            byte_count_q <= byte_count_q + 1'b1;
            if (fill_idx_q == 7'(BLOCK_BYTES - 1)) begin
              state_q       <= ST_EMIT;
              input_ready_q <= 1'b0;
              word_valid_q  <= 1'b1;
              word_idx_q    <= '0;
            end else begin
              state_q <= ST_FILL;
            end
          end else if (load_enable_i && count_full) begin
            error_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          word_idx_q <= word_idx_q + 4'd1;
          if (word_idx_q == 4'(WORDS_PER_BLOCK - 1)) begin
            state_q      <= ST_WAIT;
            word_valid_q <= 1'b0;
            wait_cnt_q   <= '0;
            last_q       <= last_now;
            if (marker_here) begin
              marker_sent_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (core_block_done_i) begin
            first_q    <= 1'b0;
            fill_idx_q <= '0;
            if (last_q) begin
              state_q    <= ST_DONE;
              msg_done_q <= 1'b1;
            end else if (complete_seen_q) begin
              // Only the length block remains; it carries no message bytes.
              state_q      <= ST_EMIT;
              word_valid_q <= 1'b1;
            end else begin
              state_q       <= ST_FILL;
              input_ready_q <= 1'b1;
            end
          end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
            // Core went silent: abandon the message and flag it.
            error_q         <= 1'b1;
            state_q         <= ST_IDLE;
            input_ready_q   <= 1'b1;
            fill_idx_q      <= '0;
            byte_count_q    <= '0;
            complete_seen_q <= 1'b0;
            marker_sent_q   <= 1'b0;
            first_q         <= 1'b1;
            last_q          <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q         <= ST_IDLE;
          input_ready_q   <= 1'b1;
          fill_idx_q      <= '0;
          byte_count_q    <= '0;
          complete_seen_q <= 1'b0;
          marker_sent_q   <= 1'b0;
          first_q         <= 1'b1;
          last_q          <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Block flags are only meaningful while a block is in flight.
  assign input_ready_o = input_ready_q;
  assign word_valid_o  = word_valid_q;
  assign word_index_o  = word_idx_q;
  assign word_data_o   = word_valid_q ? pad_word : '0;
  assign block_first_o = in_block && first_q;
  assign block_last_o  = in_block && block_last;
  assign msg_done_o    = msg_done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb_sha256_msg_sequencer: drives whole messages into the sequencer, plays
// the compression core (random done latency), and compares every emitted
// block against a FIPS 180-4 padding model built from byte queues.
module tb_sha256_msg_sequencer;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        load = 1'b0;
  logic        complete = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        coreDone = 1'b0;
  logic        inputReady;
  logic        wordValid;
  logic [31:0] wordData;
  logic [3:0]  wordIndex;
  logic        blockFirst;
  logic        blockLast;
  logic        msgDone;
  logic        error;

  always #5 clk = ~clk;

  sha256_msg_sequencer dut (
    .clk_i             (clk),
    .rst_ni            (rstN),
    .load_enable_i     (load),
    .input_complete_i  (complete),
    .input_data_i      (data),
    .input_ready_o     (inputReady),
    .word_valid_o      (wordValid),
    .word_data_o       (wordData),
    .word_index_o      (wordIndex),
    .block_first_o     (blockFirst),
    .block_last_o      (blockLast),
    .core_block_done_i (coreDone),
    .msg_done_o        (msgDone),
    .error_o           (error)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Directed messages with spot-check words ({blk, idx} -> value).
  typedef struct packed {
    logic [7:0]       len;
    logic             pat;
    logic [1:0]       nBlk;
    logic [2:0][4:0]  chkPos;
    logic [2:0][31:0] chkVal;
  } vec_t;

  vec_t vecs [5];

  logic [7:0]  msgBytes [$];
  logic [31:0] expWords [$];
  int          nExpBlocks = 0;

  bit          respOn = 1'b0;
  bit          noDone = 1'b0;
  logic [31:0] capWords [$];
  bit          capFirst [$];
  bit          capLast [$];
  int          wcnt = 0;
  int          delayLeft = 0;
  int          idxErr = 0;
  bit          waitingDone = 1'b0;
  bit          msgDoneSeen = 1'b0;

  function automatic vec_t mkVec(input int len, input bit pat, input int nBlk,
                                 input logic [14:0] pos, input logic [95:0] val);
    vec_t v;
    v.len    = 8'(len);
    v.pat    = pat;
    v.nBlk   = 2'(nBlk);
    v.chkPos = pos;
    v.chkVal = val;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: message ++ 0x80 ++ zeros to 56 mod 64 ++ 64-bit bit length.
  task automatic buildExpected();
    logic [7:0]  padded [$];
    logic [63:0] bitLen;
    padded = msgBytes;
    padded.push_back(8'h80);
    while ((padded.size() % 64) != 56) padded.push_back(8'h00);
    bitLen = 64'(msgBytes.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) padded.push_back(bitLen[8*i +: 8]);
    expWords.delete();
    for (int w = 0; w < padded.size() / 4; w++)
      expWords.push_back({padded[4*w], padded[4*w+1], padded[4*w+2], padded[4*w+3]});
  endtask

  // Core model: collects words and answers each block after a random delay.
  always @(negedge clk) begin
    if (!respOn) begin
      capWords.delete();
      capFirst.delete();
      capLast.delete();
      wcnt = 0;
      idxErr = 0;
      waitingDone = 1'b0;
      coreDone = 1'b0;
      msgDoneSeen = 1'b0;
    end else begin
      if (coreDone) begin
        coreDone = 1'b0;
        checkOutput("msg_done after core done", 512'(msgDone), 512'(capFirst.size() == nExpBlocks));
        if (msgDone) msgDoneSeen = 1'b1;
      end
      if (wordValid) begin
        if (wcnt == 0) begin
          capFirst.push_back(blockFirst);
          capLast.push_back(blockLast);
        end
        capWords.push_back(wordData);
        if (wordIndex != 4'(wcnt)) idxErr++;
        wcnt++;
        if (wcnt == 16) begin
          checkOutput("word_index sequence errors", 512'(idxErr), 512'(0));
          idxErr = 0;
          wcnt = 0;
          if (!noDone) begin
            waitingDone = 1'b1;
            delayLeft = $urandom_range(0, 4);
          end
        end
      end else if (waitingDone) begin
        if (delayLeft == 0) begin
          coreDone = 1'b1;
          waitingDone = 1'b0;
        end else begin
          delayLeft--;
        end
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!inputReady && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!inputReady) checkOutput("input_ready timeout", 512'(0), 512'(1));
  endtask

  // Feeds msgBytes then the complete pulse; optionally pokes a byte during EMIT.
  task automatic applyStimulus(input bit poke);
    for (int i = 0; i < msgBytes.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      waitReady();
      load = 1'b1;
      data = msgBytes[i];
      @(negedge clk);
      load = 1'b0;
      if ((i % 64) == 63) begin
        checkOutput("word_valid after 64th byte", 512'({wordValid, wordIndex}), 512'({1'b1, 4'd0}));
        if (poke) begin
          checkOutput("input_ready during EMIT", 512'(inputReady), 512'(0));
          load = 1'b1;
          data = 8'hEE;
          @(negedge clk);
          load = 1'b0;
        end
      end
    end
    waitReady();
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    checkOutput("word_valid after complete", 512'({wordValid, wordIndex}), 512'({1'b1, 4'd0}));
  endtask

  task automatic runMessage(input bit poke);
    int n;
    logic [511:0] actBlk, expBlk;
    respOn = 1'b0;
    repeat (2) @(negedge clk);
    buildExpected();
    nExpBlocks = expWords.size() / 16;
    respOn = 1'b1;
    applyStimulus(poke);
    n = 0;
    while (!msgDoneSeen && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!msgDoneSeen) checkOutput("msg_done timeout", 512'(0), 512'(1));
    checkOutput("block count vs model", 512'(capFirst.size()), 512'(nExpBlocks));
    for (int b = 0; b < nExpBlocks && b < capFirst.size(); b++) begin
      actBlk = '0;
      expBlk = '0;
      for (int w = 0; w < 16; w++) begin
        expBlk[511-32*w -: 32] = expWords[16*b+w];
        if (16*b + w < capWords.size()) actBlk[511-32*w -: 32] = capWords[16*b+w];
      end
      checkOutput($sformatf("block %0d words", b), actBlk, expBlk);
      checkOutput($sformatf("block %0d first", b), 512'(capFirst[b]), 512'(b == 0));
      checkOutput($sformatf("block %0d last", b), 512'(capLast[b]), 512'(b == nExpBlocks - 1));
    end
  endtask

  task automatic runTableEntry(input int k);
    int blk, idx, pos;
    logic [31:0] got;
    msgBytes.delete();
    for (int i = 0; i < int'(vecs[k].len); i++)
      msgBytes.push_back(vecs[k].pat ? 8'h41 : 8'(8'h61 + (i % 26)));
    runMessage(vecs[k].len == 8'd64);
    checkOutput($sformatf("vec%0d block count", k), 512'(capFirst.size()), 512'(vecs[k].nBlk));
    for (int j = 0; j < 3; j++) begin
      blk = int'(vecs[k].chkPos[j][4]);
      idx = int'(vecs[k].chkPos[j][3:0]);
      pos = blk * 16 + idx;
      got = (pos < capWords.size()) ? capWords[pos] : 32'hxxxxxxxx;
      checkOutput($sformatf("vec%0d blk%0d word%0d", k, blk, idx), 512'(got), 512'(vecs[k].chkVal[j]));
    end
  endtask

  initial begin
    int n;
    vecs[0] = mkVec(3, 1'b0, 1, {5'd0, 5'd14, 5'd15}, {32'h61626380, 32'h00000000, 32'h00000018});
    vecs[1] = mkVec(0, 1'b0, 1, {5'd0, 5'd14, 5'd15}, {32'h80000000, 32'h00000000, 32'h00000000});
    vecs[2] = mkVec(55, 1'b1, 1, {5'd13, 5'd14, 5'd15}, {32'h41414180, 32'h00000000, 32'h000001B8});
    vecs[3] = mkVec(56, 1'b1, 2, {5'd14, 5'd16, 5'd31}, {32'h80000000, 32'h00000000, 32'h000001C0});
    vecs[4] = mkVec(64, 1'b1, 2, {5'd15, 5'd16, 5'd31}, {32'h41414141, 32'h80000000, 32'h00000200});

    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("outputs in reset",
                512'({inputReady, wordValid, blockFirst, blockLast, msgDone, error, wordIndex, wordData}),
                512'({1'b1, 41'd0}));
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle outputs after reset",
                512'({inputReady, wordValid, blockFirst, blockLast, msgDone, error}), 512'(6'b100000));

    for (int k = 0; k < 5; k++) runTableEntry(k);

    // Reset in the middle of a block, then the same message again.
    respOn = 1'b0;
    repeat (2) @(negedge clk);
    msgBytes.delete();
    msgBytes.push_back(8'h61);
    msgBytes.push_back(8'h62);
    msgBytes.push_back(8'h63);
    applyStimulus(1'b0);
    n = 0;
    while (!(wordValid && wordIndex == 4'd7) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached word 7", 512'(wordIndex), 512'(7));
    rstN = 1'b0;
    #1;
    checkOutput("outputs after reset mid-EMIT",
                512'({inputReady, wordValid, blockFirst, blockLast, msgDone, error, wordIndex, wordData}),
                512'({1'b1, 41'd0}));
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    runTableEntry(0);

    // Core never answers: watchdog after 255 WAIT cycles.
    respOn = 1'b0;
    noDone = 1'b1;
    repeat (2) @(negedge clk);
    buildExpected();
    nExpBlocks = expWords.size() / 16;
    respOn = 1'b1;
    applyStimulus(1'b0);
    n = 0;
    while (!(wordValid && wordIndex == 4'd15) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (255) @(negedge clk);
    checkOutput("error before watchdog expiry", 512'({error, inputReady}), 512'(2'b00));
    @(negedge clk);
    checkOutput("error after 255 WAIT cycles", 512'({error, inputReady, wordValid}), 512'(3'b110));
    noDone = 1'b0;
    runTableEntry(0);
    checkOutput("error stays sticky", 512'(error), 512'(1));
    respOn = 1'b0;
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("error cleared by reset", 512'(error), 512'(0));

    // Random messages against the padding model.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 140);
      msgBytes.delete();
      for (int i = 0; i < n; i++) msgBytes.push_back(8'($urandom));
      runMessage(1'($urandom_range(0, 1)));
    end

    respOn = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
